// File: rtl/debounce_pkg.sv
// Shared types for the push-button debouncer: the debounced level and the
// rule that decides when an accepted level change is a press.
package debounce_pkg;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } btn_state_e;

  function automatic logic is_press(input btn_state_e from_st, input btn_state_e to_st);
    return (from_st == ST_RELEASED) && (to_st == ST_PRESSED);
  endfunction

endpackage

// File: rtl/debounce_if.sv
// Button-side bundle: raw button level towards the debouncer, accepted-press pulse back.
// No handshake: btn is a free-running level, btn_raise is a one-cycle pulse the consumer samples every clock.
interface debounce_if;
  logic btn;
  logic btn_raise;

  modport master (output btn, input btn_raise);
  modport slave  (input btn, output btn_raise);
endinterface

// File: rtl/debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous line; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: synchronise, require 2^DEBOUNCE_CNT stable cycles
// before accepting a level change, and pulse btn_raise once per accepted press.
module debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_raise
);

  localparam logic [DEBOUNCE_CNT-1:0] CNT_MAX = '1;

  logic                    s2;
  btn_state_e              state_q, state_d;
  logic [DEBOUNCE_CNT-1:0] cnt_q, cnt_d;
  logic                    raise_q, raise_d;
  btn_state_e              s2_state;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (s2)
  );

  assign s2_state = btn_state_e'(s2);

  // Any sample matching the current level restarts the stability window,
  // so the counter can never wrap past CNT_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raise_d = 1'b0;
    if (s2_state == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = s2_state;
      cnt_d   = '0;
      raise_d = is_press(state_q, s2_state);
    end else begin
      cnt_d = cnt_q + DEBOUNCE_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      raise_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raise_q <= raise_d;
    end
  end

  assign btn_raise = raise_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce with DEBOUNCE_CNT = 3 (8-cycle stable time): directed
// scenarios plus randomized button traffic against a run-length reference model.
module tb_debounce;

  localparam int N      = 3;
  localparam int STABLE = 1 << N;

  logic clk;
  logic rst;
  debounce_if bus ();

  debounce #(.DEBOUNCE_CNT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (bus.btn),
    .btn_raise (bus.btn_raise)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int edge_no;
  int pulses;
  int last_pulse_edge;

  // reference model state: raw button history, accepted level, run of
  // consecutive synchronised samples that disagree with the accepted level
  logic hist[$];
  logic m_level;
  int   m_run;
  logic exp_raise;
  logic exp_q[$];

  task automatic model_edge(input logic b, input logic r);
    logic sample;
    if (r) begin
      hist.delete();
      m_level   = 1'b0;
      m_run     = 0;
      exp_raise = 1'b0;
    end else begin
      // the synchronised sample seen at this edge is the button level from two edges ago
      sample = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(b);
      if (hist.size() > 4) void'(hist.pop_front());
      exp_raise = 1'b0;
      if (sample != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level   = sample;
          m_run     = 0;
          exp_raise = sample;
        end
      end else begin
        m_run = 0;
      end
    end
    exp_q.push_back(exp_raise);
  endtask

  // driver: apply one cycle of btn/rst, then check the output against the model
  task automatic step(input logic b, input logic r);
    logic e;
    @(negedge clk);
    bus.btn = b;
    rst     = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.btn_raise !== e) begin
      n_err++;
      $display("FAIL cycle_check t=%0t edge=%0d btn_raise=%b expected=%b", $time, edge_no + 1, bus.btn_raise, e);
    end
    edge_no++;
    if (bus.btn_raise === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_no;
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b1);
    edge_no         = 0;
    pulses          = 0;
    last_pulse_edge = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_hold pulses=%0d expected=0", pulses);
    end
    edge_no = 0; pulses = 0; last_pulse_edge = -1;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 1 || last_pulse_edge !== STABLE + 2) begin
      n_err++;
      $display("FAIL reset_release pulses=%0d edge=%0d expected 1 at %0d", pulses, last_pulse_edge, STABLE + 2);
    end
  endtask

  task automatic test_clean_press();
    restart();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 1 || last_pulse_edge !== 10) begin
      n_err++;
      $display("FAIL clean_press pulses=%0d edge=%0d expected 1 at 10", pulses, last_pulse_edge);
    end
  endtask

  task automatic test_bounce();
    logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    restart();
    for (int i = 0; i < 5; i++) step(pat[i], 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 1 || last_pulse_edge !== 14) begin
      n_err++;
      $display("FAIL bounce pulses=%0d edge=%0d expected 1 at 14", pulses, last_pulse_edge);
    end
  endtask

  task automatic test_short_pulse();
    restart();
    for (int i = 0; i < STABLE - 1; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL short_7 pulses=%0d expected=0", pulses);
    end
    restart();
    for (int i = 0; i < STABLE; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL short_8 pulses=%0d expected=1", pulses);
    end
  endtask

  task automatic test_release_repress();
    restart();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL first_press pulses=%0d expected=1", pulses);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL release_no_pulse pulses=%0d expected=1", pulses);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 2) begin
      n_err++;
      $display("FAIL repress pulses=%0d expected=2", pulses);
    end
  endtask

  task automatic test_reset_mid_count();
    restart();
    // s2 first reads high at edge 3, so edge 7 is the 5th stable cycle
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL mid_count_abort pulses=%0d expected=0", pulses);
    end
    edge_no = 0; pulses = 0; last_pulse_edge = -1;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    n_vec++;
    if (pulses !== 1 || last_pulse_edge !== 10) begin
      n_err++;
      $display("FAIL mid_count_restart pulses=%0d edge=%0d expected 1 at 10", pulses, last_pulse_edge);
    end
  endtask

  task automatic test_random();
    logic b;
    int   len;
    restart();
    b = 1'b0;
    for (int burst = 0; burst < 300; burst++) begin
      b   = ~b;
      len = (burst % 3 == 0) ? $urandom_range(1, 4) : $urandom_range(STABLE - 2, STABLE + 6);
      for (int i = 0; i < len; i++) step(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; edge_no = 0; pulses = 0; last_pulse_edge = -1;
    m_level = 1'b0; m_run = 0; exp_raise = 1'b0;
    rst     = 1'b1;
    bus.btn = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_pulse();
    test_release_repress();
    test_reset_mid_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
